// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: result-producer handshake, scoreboard query and
// register-file write port grouped into one bundle.
interface wb_arbiter_if #(parameter int NSRC = 3);
    logic                 stall_i;
    logic [NSRC-1:0]      src_valid_i;
    logic [NSRC*5-1:0]    src_addr_i;
    logic [NSRC*32-1:0]   src_data_i;
    logic [NSRC-1:0]      src_ready_o;
    logic                 issue_i;
    logic [4:0]           issue_rd_i;
    logic [14:0]          rs_addr_i;
    logic                 hazard_o;
    logic [31:0]          busy_o;
    logic                 wb_write_o;
    logic [4:0]           wb_addr_o;
    logic [31:0]          wb_data_o;

    modport slave (
        input  stall_i, src_valid_i, src_addr_i, src_data_i, issue_i, issue_rd_i, rs_addr_i,
        output src_ready_o, hazard_o, busy_o, wb_write_o, wb_addr_o, wb_data_o
    );

    modport master (
        output stall_i, src_valid_i, src_addr_i, src_data_i, issue_i, issue_rd_i, rs_addr_i,
        input  src_ready_o, hazard_o, busy_o, wb_write_o, wb_addr_o, wb_data_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin arbiter for the integer register-file write port, with a
// single registered output stage and a pending-write scoreboard.
module wb_arbiter #(
    parameter int NSRC = 3
) (
    input logic        clk_i,
    input logic        reset_i,
    wb_arbiter_if.slave bus
);
    localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [PW-1:0] ptr, grant;
    logic          found;
    logic          stage_free, xfer, commit;
    logic [4:0]    g_addr;
    logic [31:0]   g_data;
    logic [31:0]   busy_nxt;

    assign stage_free = !bus.wb_write_o || !bus.stall_i;
    assign commit     = bus.wb_write_o && !bus.stall_i;
    assign xfer       = found && stage_free;

    // Two passes: sources at/after ptr first, then wrap to those before it.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int j = 0; j < NSRC; j++) begin
            if (!found && bus.src_valid_i[j] && (PW'(j) >= ptr)) begin
                grant = PW'(j);
                found = 1'b1;
            end
        end
        for (int j = 0; j < NSRC; j++) begin
            if (!found && bus.src_valid_i[j]) begin
                grant = PW'(j);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        g_addr          = '0;
        g_data          = '0;
        bus.src_ready_o = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (grant == PW'(k)) begin
                g_addr             = bus.src_addr_i[5*k +: 5];
                g_data             = bus.src_data_i[32*k +: 32];
                bus.src_ready_o[k] = xfer;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr            <= '0;
            bus.wb_write_o <= 1'b0;
            bus.wb_addr_o  <= '0;
            bus.wb_data_o  <= '0;
        end else if (stage_free) begin
            if (xfer) begin
                ptr            <= (grant == PW'(NSRC-1)) ? '0 : grant + 1'b1;
                // x0 results are consumed but never written or committed
                bus.wb_write_o <= (g_addr != 5'd0);
                bus.wb_addr_o  <= g_addr;
                bus.wb_data_o  <= g_data;
            end else begin
                bus.wb_write_o <= 1'b0;
            end
        end
    end

    // Issue is applied after commit so a same-edge set on the same register wins.
    always_comb begin
        busy_nxt = bus.busy_o;
        if (commit)
            busy_nxt[bus.wb_addr_o] = 1'b0;
        if (bus.issue_i && (bus.issue_rd_i != 5'd0))
            busy_nxt[bus.issue_rd_i] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) bus.busy_o <= '0;
        else         bus.busy_o <= busy_nxt;
    end

    assign bus.hazard_o = bus.busy_o[bus.rs_addr_i[4:0]]
                        | bus.busy_o[bus.rs_addr_i[9:5]]
                        | bus.busy_o[bus.rs_addr_i[14:10]];
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed vector bench for wb_arbiter: table of per-cycle stimulus with
// hand-computed expectations, plus stall, same-edge and reset sequences.
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if #(.NSRC(3)) bus();
    wb_arbiter #(.NSRC(3)) dut (.clk_i(clk), .reset_i(rst), .bus(bus.slave));

    typedef struct {
        logic        stall;
        logic [2:0]  valid;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic        issue;
        logic [4:0]  rd;
        logic [14:0] rs;
        logic [2:0]  e_ready;
        logic        e_haz;
        logic        e_wr;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [31:0] e_busy;
    } vec_t;

    int pass_cnt = 0;
    int total    = 0;
    vec_t tbl[13];

    function automatic vec_t mk(logic stall, logic [2:0] valid,
                                logic [4:0] a0, logic [4:0] a1, logic [4:0] a2,
                                logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                                logic issue, logic [4:0] rd, logic [14:0] rs,
                                logic [2:0] e_ready, logic e_haz, logic e_wr,
                                logic [4:0] e_addr, logic [31:0] e_data, logic [31:0] e_busy);
        vec_t v;
        v.stall = stall; v.valid = valid; v.a0 = a0; v.a1 = a1; v.a2 = a2;
        v.d0 = d0; v.d1 = d1; v.d2 = d2; v.issue = issue; v.rd = rd; v.rs = rs;
        v.e_ready = e_ready; v.e_haz = e_haz; v.e_wr = e_wr;
        v.e_addr = e_addr; v.e_data = e_data; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Drive at negedge, check combinational outputs, then registered ones after the edge.
    task automatic apply(string tag, vec_t v);
        @(negedge clk);
        bus.stall_i     = v.stall;
        bus.src_valid_i = v.valid;
        bus.src_addr_i  = {v.a2, v.a1, v.a0};
        bus.src_data_i  = {v.d2, v.d1, v.d0};
        bus.issue_i     = v.issue;
        bus.issue_rd_i  = v.rd;
        bus.rs_addr_i   = v.rs;
        #1;
        chk({tag, ".ready"},  32'(bus.src_ready_o), 32'(v.e_ready));
        chk({tag, ".hazard"}, 32'(bus.hazard_o),    32'(v.e_haz));
        @(posedge clk);
        #1;
        chk({tag, ".wr"},   32'(bus.wb_write_o), 32'(v.e_wr));
        if (v.e_wr) begin
            chk({tag, ".addr"}, 32'(bus.wb_addr_o), 32'(v.e_addr));
            chk({tag, ".data"}, bus.wb_data_o,       v.e_data);
        end
        chk({tag, ".busy"}, bus.busy_o, v.e_busy);
    endtask

    initial begin
        //          stall valid   a0 a1 a2  d0           d1           d2          iss rd  rs              rdy    hz wr addr data          busy
        tbl[0]  = mk(0, 3'b000,  0, 0, 0, 0,           0,           0,           1, 5,  15'd0,          3'b000, 0, 0, 0, 0,           32'h20);
        tbl[1]  = mk(0, 3'b010,  0, 5, 0, 0,           32'hDEADBEEF,0,           0, 0,  15'd5,          3'b010, 1, 1, 5, 32'hDEADBEEF,32'h20);
        tbl[2]  = mk(0, 3'b000,  0, 0, 0, 0,           0,           0,           0, 0,  15'd5,          3'b000, 1, 0, 0, 0,           32'h0);
        tbl[3]  = mk(0, 3'b100,  0, 0, 0, 0,           0,           32'h5555,    1, 0,  15'd0,          3'b100, 0, 0, 0, 0,           32'h0);
        tbl[4]  = mk(0, 3'b111,  1, 2, 3, 32'h11,      32'h22,      32'h33,      0, 0,  15'd0,          3'b001, 0, 1, 1, 32'h11,      32'h0);
        tbl[5]  = mk(0, 3'b111,  1, 2, 3, 32'h11,      32'h22,      32'h33,      0, 0,  15'd0,          3'b010, 0, 1, 2, 32'h22,      32'h0);
        tbl[6]  = mk(0, 3'b111,  1, 2, 3, 32'h11,      32'h22,      32'h33,      0, 0,  15'd0,          3'b100, 0, 1, 3, 32'h33,      32'h0);
        tbl[7]  = mk(0, 3'b111,  1, 2, 3, 32'h11,      32'h22,      32'h33,      0, 0,  15'd0,          3'b001, 0, 1, 1, 32'h11,      32'h0);
        tbl[8]  = mk(0, 3'b000,  0, 0, 0, 0,           0,           0,           0, 0,  15'd0,          3'b000, 0, 0, 0, 0,           32'h0);
        tbl[9]  = mk(0, 3'b001,  1, 0, 0, 32'h11,      0,           0,           0, 0,  15'd0,          3'b001, 0, 1, 1, 32'h11,      32'h0);
        tbl[10] = mk(0, 3'b101,  1, 0, 4, 32'h11,      0,           32'h44,      0, 0,  15'd0,          3'b100, 0, 1, 4, 32'h44,      32'h0);
        tbl[11] = mk(0, 3'b000,  0, 0, 0, 0,           0,           0,           1, 9,  15'd9,          3'b000, 0, 0, 0, 0,           32'h200);
        tbl[12] = mk(0, 3'b000,  0, 0, 0, 0,           0,           0,           0, 0,  {5'd9,10'd0},   3'b000, 1, 0, 0, 0,           32'h200);

        bus.stall_i = 0; bus.src_valid_i = '0; bus.src_addr_i = '0; bus.src_data_i = '0;
        bus.issue_i = 0; bus.issue_rd_i = '0; bus.rs_addr_i = '0;
        #2;
        chk("reset.wr",   32'(bus.wb_write_o), 0);
        chk("reset.addr", 32'(bus.wb_addr_o),  0);
        chk("reset.data", bus.wb_data_o,        0);
        chk("reset.busy", bus.busy_o,           0);
        chk("reset.ready",32'(bus.src_ready_o), 0);
        @(negedge clk); @(negedge clk);
        rst = 0;

        for (int i = 0; i < 13; i++) apply($sformatf("vec%0d", i), tbl[i]);

        // Same-edge issue and commit on r9: set wins, then a later commit clears it.
        apply("same.load",  mk(0, 3'b001, 9, 0, 0, 32'h99, 0, 0, 0, 0, 15'd0, 3'b001, 0, 1, 9, 32'h99, 32'h200));
        apply("same.edge",  mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 9, 15'd9, 3'b000, 1, 0, 0, 0, 32'h200));
        apply("same.load2", mk(0, 3'b001, 9, 0, 0, 32'h99, 0, 0, 0, 0, 15'd0, 3'b001, 0, 1, 9, 32'h99, 32'h200));
        apply("same.clr",   mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 15'd9, 3'b000, 1, 0, 0, 0, 32'h0));

        // Stall with r7 held in the stage; src0 waits, then goes in as r7 commits.
        apply("stall.load", mk(0, 3'b010, 0, 7, 0, 0, 32'h77, 0, 1, 7, 15'd0, 3'b010, 0, 1, 7, 32'h77, 32'h80));
        for (int c = 0; c < 3; c++)
            apply($sformatf("stall.hold%0d", c),
                  mk(1, 3'b001, 8, 0, 0, 32'h88, 0, 0, 0, 0, 15'd7, 3'b000, 1, 1, 7, 32'h77, 32'h80));
        apply("stall.rel",  mk(0, 3'b001, 8, 0, 0, 32'h88, 0, 0, 0, 0, 15'd7, 3'b001, 1, 1, 8, 32'h88, 32'h0));
        apply("stall.idle", mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 15'd0, 3'b000, 0, 0, 0, 0, 32'h0));

        // Build busy=0xF00 with a write in flight, then reset mid-operation.
        apply("rst.i8",  mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 8,  15'd0, 3'b000, 0, 0, 0, 0, 32'h100));
        apply("rst.i9",  mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 9,  15'd0, 3'b000, 0, 0, 0, 0, 32'h300));
        apply("rst.i10", mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 10, 15'd0, 3'b000, 0, 0, 0, 0, 32'h700));
        apply("rst.i11", mk(0, 3'b010, 0, 8, 0, 0, 32'h1234, 0, 1, 11, 15'd0, 3'b010, 0, 1, 8, 32'h1234, 32'hF00));
        @(negedge clk);
        bus.src_valid_i = '0; bus.issue_i = 0; bus.rs_addr_i = 15'd8;
        rst = 1;
        #1;
        chk("rst.wr",     32'(bus.wb_write_o), 0);
        chk("rst.addr",   32'(bus.wb_addr_o),  0);
        chk("rst.data",   bus.wb_data_o,        0);
        chk("rst.busy",   bus.busy_o,           0);
        chk("rst.hazard", 32'(bus.hazard_o),    0);
        @(negedge clk);
        rst = 0;
        apply("rst.ptr", mk(0, 3'b111, 3, 4, 6, 32'hA0, 32'hA1, 32'hA2, 0, 0, 15'd0, 3'b001, 0, 1, 3, 32'hA0, 32'h0));

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NSRC, default 3, meaning number of result producers competing for the integer register-file write port.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port stall_i  input  1  pipeline stall; same signal the register file sees, so no write commits while high.
REQ-005 SHALL have port src_valid_i  input  NSRC  per-source result valid.
REQ-006 SHALL have port src_addr_i  input  NSRC*5  per-source destination register, source k in bits [5k+4:5k].
REQ-007 SHALL have port src_data_i  input  NSRC*32  per-source result data, source k in bits [32k+31:32k].
REQ-008 SHALL have port src_ready_o  output  NSRC  per-source accept; at most one bit high per cycle.
REQ-009 SHALL have port issue_i  input  1  an instruction with a destination register issues this cycle.
REQ-010 SHALL have port issue_rd_i  input  5  destination register of the issuing instruction.
REQ-011 SHALL have port rs_addr_i  input  15  three source-register queries {rs3,rs2,rs1}, 5 bits each.
REQ-012 SHALL have port hazard_o  output  1  high if any queried register is pending writeback.
REQ-013 SHALL have port busy_o  output  32  scoreboard, bit r high while register r is pending.
REQ-014 SHALL have port wb_write_o  output  1  register-file write enable.
REQ-015 SHALL have port wb_addr_o  output  5  register-file write address.
REQ-016 SHALL have port wb_data_o  output  32  register-file write data.

Function
REQ-017 SHALL hold one output stage (wb_write_o/wb_addr_o/wb_data_o, registered); stage is "free" when wb_write_o==0 or stall_i==0.
REQ-018 SHALL perform a source transfer when src_valid_i[k] && src_ready_o[k]; source holds addr/data stable until transfer.
REQ-019 SHALL assert src_ready_o[k] combinationally only for the granted source k, and only when stage is free; never asserts ready to a non-valid source.
REQ-020 SHALL arbitrate round-robin: grant = first valid source at or after pointer ptr (wrapping NSRC-1 -> 0); on a transfer ptr <= grant+1 modulo NSRC; ptr unchanged otherwise.
REQ-021 SHALL load the output stage on the edge after a transfer: wb_write_o<=1, wb_addr_o<=addr, wb_data_o<=data; latency source transfer -> wb_write_o = 1 cycle.
REQ-022 SHALL treat a transfer with addr 0 as accepted and discarded: wb_write_o<=0, no scoreboard change.
REQ-023 SHALL, when stage is free and no transfer occurs, load wb_write_o<=0 (addr/data may hold).
REQ-024 SHALL hold all three outputs unchanged while wb_write_o==1 && stall_i==1.
REQ-025 SHALL define commit as wb_write_o==1 && stall_i==0 on a rising edge; commit clears busy_o[wb_addr_o].
REQ-026 SHALL set busy_o[issue_rd_i] on an edge with issue_i==1 && issue_rd_i!=0; issue ignored for x0.
REQ-027 SHALL, on same-edge issue and commit to the same register, leave the bit set (set wins).
REQ-028 SHALL keep busy_o[0] constantly 0.
REQ-029 SHALL compute hazard_o combinationally = busy_o[rs1]|busy_o[rs2]|busy_o[rs3] from current registered busy_o (no bypass of this cycle's commit).
REQ-030 SHALL support back-to-back commits: with stall_i low and continuous valid sources, one write per cycle.

Reset
REQ-031 SHALL on reset_i asynchronously clear wb_write_o, wb_addr_o, wb_data_o, busy_o to 0 and ptr to 0; src_ready_o and hazard_o then follow from inputs.
REQ-032 SHALL discard any in-flight output-stage write on reset mid-operation; no write commits in the reset cycle.

Verification
REQ-033 SHALL pass: src1 valid addr 5 data 0xDEADBEEF, stall low -> ready[1]=1, next cycle wb_write_o=1 addr 5 data 0xDEADBEEF, busy_o[5] cleared on following edge.
REQ-034 SHALL pass: all 3 sources valid continuously, ptr=0 -> grants 0,1,2,0 on consecutive cycles, wb_write_o high each cycle.
REQ-035 SHALL pass: stage holds addr 7, stall_i high 3 cycles with src0 valid -> outputs frozen, ready all 0; stall drops -> commit r7, src0 accepted same cycle.
REQ-036 SHALL pass: issue_i with rd 9, rs1 query 9 -> hazard_o=1 next cycle; same-edge issue rd 9 and commit r9 -> busy_o[9] stays 1.
REQ-037 SHALL pass: src2 transfer with addr 0 -> wb_write_o stays 0, busy_o unchanged; issue rd 0 -> busy_o[0]=0.
REQ-038 SHALL pass: reset_i pulsed while wb_write_o=1 and busy_o=0x0000_0F00 -> all outputs 0 immediately, ptr restarts at source 0.
